// File: rtl/usb_phy_reset_seq_if.sv
// rtl/usb_phy_reset_seq_if.sv - Board-side control and status signals of the USB PHY/hub reset sequencer
interface usb_phy_reset_seq_if;
  logic usb_rst_req_i;
  logic ulpi_act_tgl_i;
  logic phy_rst_o;
  logic hub_rst_n_o;
  logic usb_rst_o;
  logic ready_o;
  logic fault_o;

  modport master (
    input  usb_rst_req_i,
    input  ulpi_act_tgl_i,
    output phy_rst_o,
    output hub_rst_n_o,
    output usb_rst_o,
    output ready_o,
    output fault_o
  );

  modport slave (
    output usb_rst_req_i,
    output ulpi_act_tgl_i,
    input  phy_rst_o,
    input  hub_rst_n_o,
    input  usb_rst_o,
    input  ready_o,
    input  fault_o
  );
endinterface

// File: rtl/usb_phy_reset_seq.sv
// rtl/usb_phy_reset_seq.sv - USB3300 PHY / hub / core reset sequencer gated on ULPI clock activity
// Optional feature macro: USB_RST_RETRY_EN (retry WAIT_CLK timeouts before declaring a fault).
module usb_phy_reset_seq #(
  parameter int unsigned CLK_FREQ     = 60000000,
  parameter int unsigned PHY_RST_US   = 10,
  parameter int unsigned HUB_RST_US   = 100,
  parameter int unsigned CLK_WAIT_US  = 1000,
  parameter int unsigned STABLE_EDGES = 8,
  parameter int unsigned MISS_CYC     = 64,
  parameter int unsigned MAX_RETRY    = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  usb_phy_reset_seq_if.master ctl
);

  localparam longint unsigned CYC_PER_US    = longint'(CLK_FREQ) / 64'd1000000;
  localparam longint unsigned PHY_RST_CYC   = CYC_PER_US * longint'(PHY_RST_US);
  localparam longint unsigned HUB_RST_CYC   = CYC_PER_US * longint'(HUB_RST_US);
  localparam longint unsigned CLK_WAIT_CYC  = CYC_PER_US * longint'(CLK_WAIT_US);
  localparam longint unsigned CNT_LIMIT     = (64'd1 << 24) - 64'd1;
  localparam int              GAP_W         = $clog2(MISS_CYC + 1);

  if (PHY_RST_CYC > CNT_LIMIT) begin : g_phy_rst_too_long
    $error("PHY_RST delay does not fit the 24-bit counter");
  end
  if (HUB_RST_CYC > CNT_LIMIT) begin : g_hub_rst_too_long
    $error("HUB_RST delay does not fit the 24-bit counter");
  end
  if (CLK_WAIT_CYC > CNT_LIMIT) begin : g_clk_wait_too_long
    $error("CLK_WAIT delay does not fit the 24-bit counter");
  end
  if (STABLE_EDGES < 1 || STABLE_EDGES > 15) begin : g_stable_range
    $error("STABLE_EDGES must fit the 4-bit edge counter");
  end
  if (MISS_CYC < 1) begin : g_miss_range
    $error("MISS_CYC must be at least 1");
  end
  if (MAX_RETRY > 3) begin : g_retry_range
    $error("MAX_RETRY must fit the 2-bit retry counter");
  end

  localparam logic [23:0]      PHY_LOAD    = 24'(PHY_RST_CYC);
  localparam logic [23:0]      HUB_LOAD    = 24'(HUB_RST_CYC);
  localparam logic [23:0]      WAIT_LOAD   = 24'(CLK_WAIT_CYC);
  // Loaded with 15 so SETTLE lasts exactly 16 cycles including the exit cycle.
  localparam logic [23:0]      SETTLE_LOAD = 24'd15;
  localparam logic [3:0]       STABLE_CNT  = 4'(STABLE_EDGES);
  localparam logic [GAP_W-1:0] GAP_MAX     = GAP_W'(MISS_CYC);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_CLK,
    ST_HUB_HOLD,
    ST_SETTLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e           state_q;
  logic [23:0]      cnt_q;
  logic [2:0]       sync_q;
  logic             req_q;
  logic [3:0]       edge_cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             phy_rst_q;
  logic             hub_rst_n_q;
  logic             usb_rst_q;
  logic             ready_q;
  logic             fault_q;

  logic req;
  logic req_rise;
  logic act_edge;
  logic clk_lost;
  logic clk_stable;
  logic cnt_zero;
  logic wait_timeout;
  logic retry_done;
  logic restart;

  assign req          = ctl.usb_rst_req_i;
  assign req_rise     = req & ~req_q;
  assign act_edge     = sync_q[1] ^ sync_q[2];
  assign clk_lost     = (gap_q == GAP_MAX);
  assign clk_stable   = (edge_cnt_q == STABLE_CNT);
  assign cnt_zero     = (cnt_q == '0);
  assign wait_timeout = (state_q == ST_WAIT_CLK) && !req && !clk_stable && cnt_zero;

  // Every path back to the start of the sequence funnels through restart.
  assign restart = (req && state_q != ST_FAULT)
                || (req_rise && state_q == ST_FAULT)
                || (clk_lost && state_q == ST_RUN)
                || (wait_timeout && !retry_done);

`ifdef USB_RST_RETRY_EN
  logic [1:0] retry_cnt_q;

  assign retry_done = (retry_cnt_q == 2'(MAX_RETRY));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_cnt_q <= '0;
    end else if (state_q == ST_SETTLE && cnt_zero && !req) begin
      retry_cnt_q <= '0;
    end else if (wait_timeout && !retry_done) begin
      retry_cnt_q <= retry_cnt_q + 2'd1;
    end
  end
`else
  assign retry_done = 1'b1;
`endif

  // Edges seen while the PHY is held in reset do not count towards qualification.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      req_q      <= 1'b0;
      gap_q      <= '0;
      edge_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ctl.ulpi_act_tgl_i};
      req_q  <= req;
      if (act_edge) begin
        gap_q <= '0;
      end else if (!clk_lost) begin
        gap_q <= gap_q + 1'b1;
      end
      if (state_q == ST_ASSERT || state_q == ST_FAULT) begin
        edge_cnt_q <= '0;
      end else if (act_edge) begin
        if (!clk_stable) begin
          edge_cnt_q <= edge_cnt_q + 4'd1;
        end
      end else if (clk_lost) begin
        edge_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || restart) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= PHY_LOAD;
      phy_rst_q   <= 1'b1;
      hub_rst_n_q <= 1'b0;
      usb_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_zero) begin
            state_q   <= ST_WAIT_CLK;
            cnt_q     <= WAIT_LOAD;
            phy_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        ST_WAIT_CLK: begin
          if (clk_stable) begin
            state_q <= ST_HUB_HOLD;
            cnt_q   <= HUB_LOAD;
          end else if (cnt_zero) begin
            state_q   <= ST_FAULT;
            phy_rst_q <= 1'b1;
            fault_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        ST_HUB_HOLD: begin
          if (cnt_zero) begin
            state_q     <= ST_SETTLE;
            cnt_q       <= SETTLE_LOAD;
            hub_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q   <= ST_RUN;
            usb_rst_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_ASSERT;
          cnt_q   <= PHY_LOAD;
        end
      endcase
    end
  end

  assign ctl.phy_rst_o   = phy_rst_q;
  assign ctl.hub_rst_n_o = hub_rst_n_q;
  assign ctl.usb_rst_o   = usb_rst_q;
  assign ctl.ready_o     = ready_q;
  assign ctl.fault_o     = fault_q;

endmodule

// File: tb/tb_usb_phy_reset_seq.sv
// tb/tb_usb_phy_reset_seq.sv - Self-checking bench for usb_phy_reset_seq against a timestamp-based reference model
module tb_usb_phy_reset_seq;

  localparam int PHY    = 10;
  localparam int HUB    = 20;
  localparam int CW     = 50;
  localparam int STABLE = 8;
  localparam int MISS   = 64;
  localparam int SETTLE = 16;
  localparam int MAXR   = 3;

  localparam int PH_ASSERT = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_HUB    = 2;
  localparam int PH_SETTLE = 3;
  localparam int PH_RUN    = 4;
  localparam int PH_FAULT  = 5;

  localparam logic [4:0] RESET_OUTS = 5'b10100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_phy_reset_seq_if bus ();

  usb_phy_reset_seq #(
    .CLK_FREQ    (1000000),
    .PHY_RST_US  (PHY),
    .HUB_RST_US  (HUB),
    .CLK_WAIT_US (CW),
    .STABLE_EDGES(STABLE),
    .MISS_CYC    (MISS),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ctl  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // stimulus
  logic req = 1'b0;
  logic tgl_run = 1'b1;
  logic tgl_val = 1'b0;
  int   tgl_div = 0;

  // model: absolute-cycle deadlines instead of down-counters
  int   n;
  int   m_phase;
  int   m_due;
  int   m_ecnt;
  int   m_last_edge;
  int   m_retry;
  logic m_req_prev;
  logic h1, h2, h3;

  // observation bookkeeping (cycle numbers since last reset release)
  logic [4:0] prev_obs = RESET_OUTS;
  int last_phy_fall, last_phy_rise, last_hub_rise, last_usb_fall, last_fault, last_ready_fall;
  int phy_falls;

  function automatic logic [4:0] outs_of(input int ph);
    case (ph)
      PH_WAIT:   return 5'b00100;
      PH_HUB:    return 5'b00100;
      PH_SETTLE: return 5'b01100;
      PH_RUN:    return 5'b01010;
      PH_FAULT:  return 5'b10101;
      default:   return RESET_OUTS;
    endcase
  endfunction

  function automatic logic [4:0] obs();
    return {bus.phy_rst_o, bus.hub_rst_n_o, bus.usb_rst_o, bus.ready_o, bus.fault_o};
  endfunction

  task automatic go_assert();
    m_phase = PH_ASSERT;
    m_due   = n + PHY + 1;
  endtask

  task automatic model_step();
    logic ev, lost, rise;
    int   gap, old;
    if (rst) begin
      n = 0; m_phase = PH_ASSERT; m_due = PHY + 1; m_ecnt = 0; m_last_edge = 0;
      m_retry = 0; m_req_prev = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      return;
    end
    n++;
    ev   = (h2 != h3);
    gap  = n - 1 - m_last_edge;
    if (gap > MISS) gap = MISS;
    lost = (gap == MISS);
    rise = req && !m_req_prev;
    old  = m_phase;
    if (old == PH_FAULT) begin
      if (rise) go_assert();
    end else if (req) begin
      go_assert();
    end else begin
      case (old)
        PH_ASSERT: if (n == m_due) begin m_phase = PH_WAIT; m_due = n + CW + 1; end
        PH_WAIT: begin
          if (m_ecnt == STABLE) begin
            m_phase = PH_HUB; m_due = n + HUB + 1;
          end else if (n == m_due) begin
`ifdef USB_RST_RETRY_EN
            if (m_retry < MAXR) begin m_retry++; go_assert(); end
            else m_phase = PH_FAULT;
`else
            m_phase = PH_FAULT;
`endif
          end
        end
        PH_HUB:    if (n == m_due) begin m_phase = PH_SETTLE; m_due = n + SETTLE; end
        PH_SETTLE: if (n == m_due) begin m_phase = PH_RUN; m_retry = 0; end
        PH_RUN:    if (lost) go_assert();
        default: ;
      endcase
    end
    if (old == PH_ASSERT || old == PH_FAULT) m_ecnt = 0;
    else if (ev) begin if (m_ecnt < STABLE) m_ecnt++; end
    else if (lost) m_ecnt = 0;
    if (ev) m_last_edge = n;
    h3 = h2; h2 = h1; h1 = tgl_val; m_req_prev = req;
  endtask

  task automatic tick();
    logic [4:0] o;
    if (tgl_run) begin
      tgl_div++;
      if (tgl_div == 4) begin tgl_div = 0; tgl_val = ~tgl_val; end
    end
    bus.ulpi_act_tgl_i = tgl_val;
    bus.usb_rst_req_i  = req;
    @(posedge clk);
    model_step();
    #1;
    o = obs();
    check("outs", o, outs_of(m_phase));
    if (prev_obs[4] && !o[4]) begin last_phy_fall = n; phy_falls++; end
    if (!prev_obs[4] && o[4]) last_phy_rise = n;
    if (!prev_obs[3] && o[3]) last_hub_rise = n;
    if (prev_obs[2] && !o[2]) last_usb_fall = n;
    if (prev_obs[1] && !o[1]) last_ready_fall = n;
    if (!prev_obs[0] && o[0]) last_fault = n;
    prev_obs = o;
  endtask

  initial begin
    int req_left, rst_left;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outs", obs(), RESET_OUTS);
    check("reset_cnt", 32'(dut.cnt_q), PHY);

    // power-up with toggle running
    rst = 1'b0;
    for (int i = 0; i < 300 && !bus.ready_o; i++) tick();
    check("powerup_ready", bus.ready_o, 1);
    check("phy_fall_cycle", last_phy_fall, PHY + 1);
    check("hub_after_qual", (last_hub_rise - last_phy_fall) >= (HUB + 1 + 4 * (STABLE - 1)), 1);
    check("hub_to_usb", last_usb_fall - last_hub_rise, SETTLE);

    // clock lost in RUN
    repeat (20) tick();
    tgl_run = 1'b0;
    for (int i = 0; i < 200 && bus.ready_o; i++) tick();
    check("loss_ready", bus.ready_o, 0);
    check("loss_outs", obs(), RESET_OUTS);
    check("loss_latency", last_ready_fall - m_last_edge, MISS + 1);

    // static toggle ends in fault
    phy_falls = 0;
    for (int i = 0; i < 1500 && !bus.fault_o; i++) tick();
    check("fault_set", bus.fault_o, 1);
    check("fault_phy", bus.phy_rst_o, 1);
    check("fault_wait_len", last_fault - last_phy_fall, CW + 1);
`ifdef USB_RST_RETRY_EN
    check("attempts", phy_falls, MAXR + 1);
`else
    check("attempts", phy_falls, 1);
`endif
    repeat (10) tick();
    check("fault_hold", obs(), 5'b10101);

    // rising request leaves fault
    req = 1'b1;
    tick();
    check("fault_exit", obs(), RESET_OUTS);
    repeat (2) tick();
    req = 1'b0;
    tgl_run = 1'b1;
    for (int i = 0; i < 300 && m_phase != PH_HUB; i++) tick();
    check("reach_hub", m_phase, PH_HUB);

    // 5-cycle request during HUB_HOLD
    repeat (3) tick();
    req = 1'b1;
    repeat (5) tick();
    req = 1'b0;
    for (int i = 0; i < 100 && bus.phy_rst_o; i++) tick();
    check("req_pulse_phy_len", last_phy_fall - last_phy_rise, 5 + PHY);

    // reset mid-SETTLE
    for (int i = 0; i < 300 && m_phase != PH_SETTLE; i++) tick();
    check("reach_settle", m_phase, PH_SETTLE);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("settle_rst_outs", obs(), RESET_OUTS);
    check("settle_rst_cnt", 32'(dut.cnt_q), PHY);
    rst = 1'b0;
    repeat (PHY + 1) tick();
    check("rerun_phy_fall", last_phy_fall, PHY + 1);

    // randomized soak
    req_left = 0;
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) tgl_run = ~tgl_run;
      if (req_left > 0) req_left--;
      else if ($urandom_range(0, 199) == 0) req_left = $urandom_range(1, 8);
      req = (req_left > 0);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 799) == 0) rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_phy_reset_seq.md
# usb_phy_reset_seq

Power-up and on-demand reset sequencer for the USB3300 ULPI PHY and the on-board USB hub. It runs in the master clock domain and drives the PHY reset, the hub reset and the core-side USB reset. It releases them in order, and only after the PHY's 60 MHz ULPI clock is confirmed running. It also re-enters reset if that clock is later lost.

## Interface
Parameters:
- CLK_FREQ, 60000000, master clock frequency in Hz
- PHY_RST_US, 10, PHY reset pulse width in µs
- HUB_RST_US, 100, hub reset hold after the ULPI clock is confirmed, in µs
- CLK_WAIT_US, 1000, maximum wait for ULPI clock activity after PHY release, in µs
- STABLE_EDGES, 8, consecutive activity edges needed to declare the ULPI clock alive
- MISS_CYC, 64, master cycles without an activity edge that count as clock lost
- MAX_RETRY, 3, retries before fault (only with USB_RST_RETRY_EN)

Ports:
- clk_i, in, 1, master clock; the only clock
- rst_i, in, 1, synchronous active-high reset
- usb_rst_req_i, in, 1, software reset request (GPIO bit 7), level-sensitive
- ulpi_act_tgl_i, in, 1, activity toggle from the ULPI domain; inverts every 8 ULPI clocks; asynchronous to clk_i
- phy_rst_o, out, 1, USB3300 reset, active-high
- hub_rst_n_o, out, 1, hub reset, active-low
- usb_rst_o, out, 1, reset to the USB core and ULPI wrapper, active-high
- ready_o, out, 1, sequence complete, link usable
- fault_o, out, 1, ULPI clock never appeared

## Operation
Cycle counts:
- Each delay in cycles = (CLK_FREQ/1000000) × US.
- Delays are computed at elaboration; the down-counter is 24 bits. An elaboration error is raised if any delay exceeds 2^24−1.

Activity detection:
- ulpi_act_tgl_i passes through a 3-flop synchroniser. Any change between flops 2 and 3 is one edge.
- edge_cnt (4 bits) increments on each edge and saturates at STABLE_EDGES.
- A gap counter counts cycles since the last edge. When it reaches MISS_CYC, edge_cnt clears to 0.

State machine (all outputs registered):
- ASSERT: phy_rst_o=1, hub_rst_n_o=0, usb_rst_o=1. The counter loads PHY_RST cycles. Stay while usb_rst_req_i=1. Go to WAIT_CLK when the counter reaches 0 with the request low.
- WAIT_CLK: phy_rst_o=0. The counter loads CLK_WAIT cycles on entry.
  - When edge_cnt reaches STABLE_EDGES, go to HUB_HOLD.
  - When the counter reaches 0, handle the timeout as described under Configuration.
- HUB_HOLD: the counter loads HUB_RST cycles. At 0, set hub_rst_n_o=1 and go to SETTLE.
- SETTLE: hold for 16 cycles, then set usb_rst_o=0 and ready_o=1 and go to RUN.
- RUN: stay until the ULPI clock is lost (gap counter reaches MISS_CYC) or usb_rst_req_i=1. Either event goes to ASSERT; all outputs return to their reset values on the next edge.
- FAULT: fault_o=1, phy_rst_o=1, hub_rst_n_o=0, usb_rst_o=1. Exit only on rst_i or a rising edge of usb_rst_req_i, either of which goes to ASSERT.

Priority:
- rst_i is highest.
- usb_rst_req_i=1 forces ASSERT from any state except FAULT, where only a rising edge counts.
- If a clock-lost event and a request occur in the same cycle, the result is ASSERT either way.

## Timing
- Reset values: phy_rst_o=1, hub_rst_n_o=0, usb_rst_o=1, ready_o=0, fault_o=0. State is ASSERT with the counter loaded.
- Output changes appear one cycle after the state transition.
- phy_rst_o falling to hub_rst_n_o rising takes at least the edge-qualification time plus HUB_RST cycles.
- hub_rst_n_o rising to usb_rst_o falling takes exactly 16 cycles; ready_o rises in the same cycle that usb_rst_o falls.
- Synchroniser latency is 3 cycles. Loss-detection latency is MISS_CYC+1 cycles after the last edge.
- A request asserted mid-sequence restarts the full PHY_RST pulse from its beginning.

## Configuration
USB_RST_RETRY_EN:
- Defined: a WAIT_CLK timeout increments retry_cnt (2 bits) and returns to ASSERT. When retry_cnt is already at MAX_RETRY, the timeout goes to FAULT instead. retry_cnt clears on rst_i and on entering RUN.
- Undefined: a WAIT_CLK timeout goes directly to FAULT, and no retry counter is instantiated.

## Test plan
Bench parameters: CLK_FREQ=1000000, PHY_RST_US=10, HUB_RST_US=20, CLK_WAIT_US=50, STABLE_EDGES=8, MISS_CYC=64. The toggle inverts every 4 cycles when running.
- Power-up with the toggle running: phy_rst_o falls at cycle 11 after rst_i deasserts, hub_rst_n_o rises 20 cycles after 8 edges are qualified, and usb_rst_o=0 with ready_o=1 exactly 16 cycles after that.
- Toggle held static, macro undefined: fault_o=1 after 50 cycles in WAIT_CLK, phy_rst_o=1 again. A rising edge on usb_rst_req_i then restarts the sequence.
- Toggle held static, USB_RST_RETRY_EN defined: three full ASSERT/WAIT_CLK retries, then fault_o=1. With the toggle started during the 2nd retry, reaching RUN clears retry_cnt.
- In RUN, stop the toggle: after 64 cycles with no edge, ready_o=0, usb_rst_o=1, hub_rst_n_o=0 and phy_rst_o=1 on the following cycle.
- usb_rst_req_i pulsed high for 5 cycles during HUB_HOLD: return to ASSERT, phy_rst_o=1 for 5+10 cycles, then the full sequence reruns.
- rst_i asserted mid-SETTLE: all outputs return to their reset values on the next edge and the counter reloads to 10.
